// File: rtl/aes_key_schedule_if.sv
// -----------------------------------------------------------------------------
// aes_key_schedule_if
//   Bundles the key schedule's control handshake and round-key read port.
//   master: key register / cipher side (drives start, mode, key_in, rd_idx)
//   slave : aes_key_schedule (drives busy, done, key_ready, err, num_rounds,
//           rd_key)
//   Signals:
//     start      request expansion of key_in with mode
//     mode       00=AES-128, 01=AES-192, 10=AES-256, 11=illegal
//     key_in     cipher key, MSB-aligned (w[0] = key_in[255:224])
//     busy       expansion in progress
//     done       one-cycle completion pulse
//     key_ready  schedule valid
//     err        illegal/unsupported mode at last start
//     num_rounds Nr of the current schedule
//     rd_idx     round key index
//     rd_key     registered round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}
// -----------------------------------------------------------------------------
interface aes_key_schedule_if;
   logic         start;
   logic [1:0]   mode;
   logic [255:0] key_in;
   logic         busy;
   logic         done;
   logic         key_ready;
   logic         err;
   logic [3:0]   num_rounds;
   logic [3:0]   rd_idx;
   logic [127:0] rd_key;

   modport master (
      output start, mode, key_in, rd_idx,
      input  busy, done, key_ready, err, num_rounds, rd_key
   );

   modport slave (
      input  start, mode, key_in, rd_idx,
      output busy, done, key_ready, err, num_rounds, rd_key
   );
endinterface

// File: rtl/aes_key_schedule.sv
// -----------------------------------------------------------------------------
// aes_key_schedule
//   FIPS-197 key expansion for AES-128/192/256, selected per run by mode.
//   The key words are loaded on the accepted start edge, then one schedule
//   word is produced per clock into internal storage. Round keys are served
//   over a registered random-access read port.
//   Ports:
//     clk  clock, all logic on posedge
//     rst  synchronous active-high reset
//     bus  aes_key_schedule_if.slave (handshake, key input, read port)
//   Parameter:
//     MAX_KEY_BITS  largest supported key (128, 192 or 256); sizes storage
// -----------------------------------------------------------------------------
module aes_key_schedule #(
   parameter int MAX_KEY_BITS = 256
) (
   input  logic              clk,
   input  logic              rst,
   aes_key_schedule_if.slave bus
);
   localparam int MAX_NK    = MAX_KEY_BITS / 32;
   localparam int MAX_WORDS = 4 * (MAX_NK + 7);

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] EXPAND = 1'b1;

   // AES S-box, entry 0 in the most significant byte
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   logic [31:0]  wordMem [MAX_WORDS];

   logic [0:0]   stateQ, stateD;
   logic [5:0]   wordCntQ, wordCntD;
   logic [5:0]   lastIdxQ, lastIdxD;
   logic [2:0]   modCntQ, modCntD;
   logic [3:0]   nkQ, nkD;
   logic [7:0]   rconQ, rconD;
   logic         busyQ, busyD;
   logic         doneQ, doneD;
   logic         readyQ, readyD;
   logic         errQ, errD;
   logic [3:0]   nrQ, nrD;
   logic [127:0] rdKeyQ, rdKeyD;

   logic         modeLegal;
   logic         accept;
   logic [3:0]   startNk;
   logic [31:0]  prevWord, backWord, subIn, subOut, tempWord, newWord;

   // Byte index b lives at bit offset (255-b)*8, which is simply ~b shifted by 3
   function automatic logic [7:0] sboxLookup(input logic [7:0] b);
      logic [10:0] base;
      base = {~b, 3'b000};
      return SBOX[base +: 8];
   endfunction

   function automatic logic [31:0] subWord(input logic [31:0] w);
      return {sboxLookup(w[31:24]), sboxLookup(w[23:16]),
              sboxLookup(w[15:8]),  sboxLookup(w[7:0])};
   endfunction

   // Decode the requested key length and decide whether this instance can
   // hold it; a key wider than the storage was sized for is treated as illegal
   always_comb begin
      startNk   = 4'd4 + {1'b0, bus.mode, 1'b0};
      modeLegal = (bus.mode != 2'b11) && ((32 * int'(startNk)) <= MAX_KEY_BITS);
      accept    = (stateQ == IDLE) && bus.start && modeLegal;
   end

   // One schedule word per cycle: w[i] = w[i-Nk] ^ f(w[i-1]); the modulo
   // counter stands in for i%Nk so no divider is needed
   always_comb begin
      prevWord = wordMem[wordCntQ - 6'd1];
      backWord = wordMem[wordCntQ - {2'b00, nkQ}];
      subIn    = (modCntQ == 3'd0) ? {prevWord[23:0], prevWord[31:24]} : prevWord;
      subOut   = subWord(subIn);
      if (modCntQ == 3'd0) begin
         tempWord = subOut ^ {rconQ, 24'h000000};
      end else if ((nkQ == 4'd8) && (modCntQ == 3'd4)) begin
         tempWord = subOut;
      end else begin
         tempWord = prevWord;
      end
      newWord = backWord ^ tempWord;
   end

   // Control next-state: IDLE waits for start, EXPAND walks the word counter
   // up to the last word of the schedule and then signals completion.
   // The read port is registered from the current index every cycle and is
   // forced to zero whenever the schedule is not valid or the index is past Nr.
   always_comb begin
      stateD   = stateQ;
      wordCntD = wordCntQ;
      lastIdxD = lastIdxQ;
      modCntD  = modCntQ;
      nkD      = nkQ;
      rconD    = rconQ;
      busyD    = busyQ;
      doneD    = 1'b0;
      readyD   = readyQ;
      errD     = errQ;
      nrD      = nrQ;
      rdKeyD   = '0;
      if (readyQ && (bus.rd_idx <= nrQ)) begin
         rdKeyD = {wordMem[{bus.rd_idx, 2'b00}], wordMem[{bus.rd_idx, 2'b01}],
                   wordMem[{bus.rd_idx, 2'b10}], wordMem[{bus.rd_idx, 2'b11}]};
      end
      case (stateQ)
         IDLE: begin
            if (bus.start) begin
               readyD = 1'b0;
               errD   = !modeLegal;
               if (modeLegal) begin
                  stateD   = EXPAND;
                  busyD    = 1'b1;
                  nkD      = startNk;
                  nrD      = startNk + 4'd6;
                  lastIdxD = {startNk + 4'd7, 2'b00} - 6'd1;
                  wordCntD = {2'b00, startNk};
                  modCntD  = 3'd0;
                  rconD    = 8'h01;
               end else begin
                  nrD = 4'd0;
               end
            end
         end
         EXPAND: begin
            wordCntD = wordCntQ + 6'd1;
            modCntD  = ({1'b0, modCntQ} == (nkQ - 4'd1)) ? 3'd0 : modCntQ + 3'd1;
            if (modCntQ == 3'd0) begin
               rconD = {rconQ[6:0], 1'b0} ^ (rconQ[7] ? 8'h1b : 8'h00);
            end
            if (wordCntQ == lastIdxQ) begin
               stateD = IDLE;
               busyD  = 1'b0;
               doneD  = 1'b1;
               readyD = 1'b1;
            end
         end
         default: stateD = IDLE;
      endcase
   end

   // Control and output registers; reset aborts any run in progress
   always_ff @(posedge clk) begin
      if (rst) begin
         stateQ   <= IDLE;
         wordCntQ <= '0;
         lastIdxQ <= '0;
         modCntQ  <= '0;
         nkQ      <= '0;
         rconQ    <= 8'h01;
         busyQ    <= 1'b0;
         doneQ    <= 1'b0;
         readyQ   <= 1'b0;
         errQ     <= 1'b0;
         nrQ      <= '0;
         rdKeyQ   <= '0;
      end else begin
         stateQ   <= stateD;
         wordCntQ <= wordCntD;
         lastIdxQ <= lastIdxD;
         modCntQ  <= modCntD;
         nkQ      <= nkD;
         rconQ    <= rconD;
         busyQ    <= busyD;
         doneQ    <= doneD;
         readyQ   <= readyD;
         errQ     <= errD;
         nrQ      <= nrD;
         rdKeyQ   <= rdKeyD;
      end
   end

   // Word storage is deliberately not reset; the key words all land on the
   // accepted start edge, generated words follow one per cycle
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (accept) begin
            for (int j = 0; j < 8; j++) begin
               if (j < int'(startNk)) begin
                  wordMem[j] <= bus.key_in[255 - 32 * j -: 32];
               end
            end
         end else if (stateQ == EXPAND) begin
            wordMem[wordCntQ] <= newWord;
         end
      end
   end

   assign bus.busy       = busyQ;
   assign bus.done       = doneQ;
   assign bus.key_ready  = readyQ;
   assign bus.err        = errQ;
   assign bus.num_rounds = nrQ;
   assign bus.rd_key     = rdKeyQ;
endmodule
